// File: rtl/bus_spi_pkg.sv
// Shared types and constants for the BUS SPI IQ scheduler: FSM states, word order, widths.
package bus_spi_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned NUM_WORDS      = 4;
   localparam int unsigned IDX_W          = 2;

   localparam logic [IDX_W-1:0] W_RX1_I = 2'd0;
   localparam logic [IDX_W-1:0] W_RX1_Q = 2'd1;
   localparam logic [IDX_W-1:0] W_RX2_I = 2'd2;
   localparam logic [IDX_W-1:0] W_RX2_Q = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5
   } state_e;

   // Index of the final word of a frame: RX1_Q for 2-word frames, RX2_Q for 4-word frames.
   function automatic logic [IDX_W-1:0] last_word_idx(input logic rx2);
      return rx2 ? W_RX2_Q : W_RX1_Q;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse (one clk wide).
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         prev  <= sync2;
         rise  <= sync2 & ~prev;
      end
   end

endmodule

// File: rtl/bus_spi_iq_scheduler.sv
// Schedules RX IQ frames (2 or 4 words) and a single auxiliary word onto the BUS SPI master,
// with overrun counting and SPI start timeout detection.
module bus_spi_iq_scheduler
   import bus_spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int unsigned BUSY_TIMEOUT  = 64,
   parameter int unsigned GAP_CYCLES    = 1,
   parameter int unsigned OVR_CNT_WIDTH = 8
) (
   input  logic                     spi_clk,
   input  logic                     reset_n,
   input  logic                     iq_clk,
   input  logic                     rx2_enable,
   input  logic [DATA_WIDTH-1:0]    RX1_I,
   input  logic [DATA_WIDTH-1:0]    RX1_Q,
   input  logic [DATA_WIDTH-1:0]    RX2_I,
   input  logic [DATA_WIDTH-1:0]    RX2_Q,
   output logic                     IQ_RX_READ_REQ,
   output logic                     IQ_RX_READ_CLK,
   input  logic                     aux_req,
   input  logic [DATA_WIDTH-1:0]    aux_data,
   output logic                     aux_ack,
   output logic [DATA_WIDTH-1:0]    BUS_SPI_data_out,
   output logic                     BUS_SPI_enable,
   input  logic                     BUS_SPI_busy,
   input  logic                     err_clear,
   output logic [OVR_CNT_WIDTH-1:0] overrun_count,
   output logic                     timeout_err,
   output logic [3:0]               BUS_SPI_Stage
);

   localparam int unsigned TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic iq_edge;

   sync_edge_detect u_iq_sync (
      .clk      (spi_clk),
      .rst_n    (reset_n),
      .async_in (iq_clk),
      .rise     (iq_edge)
   );

   state_e                   state, state_nxt;
   logic [IDX_W-1:0]         idx, idx_nxt;
   logic                     frame_rx2, frame_rx2_nxt;
   logic                     more, more_nxt;
   logic                     aux_active, aux_active_nxt;
   logic [DATA_WIDTH-1:0]    aux_word, aux_word_nxt;
   logic [DATA_WIDTH-1:0]    cap     [NUM_WORDS];
   logic [DATA_WIDTH-1:0]    cap_nxt [NUM_WORDS];
   logic [TMO_W-1:0]         tmo_cnt, tmo_cnt_nxt;
   logic [GAP_W-1:0]         gap_cnt, gap_cnt_nxt;
   logic [DATA_WIDTH-1:0]    data_nxt;
   logic                     enable_nxt;
   logic                     read_req_nxt;
   logic                     read_clk_nxt;
   logic                     ack_nxt;
   logic [OVR_CNT_WIDTH-1:0] ovr_nxt;
   logic                     terr_nxt;
   logic                     tmo_event;
   logic                     ovr_event;

   assign BUS_SPI_Stage = {state, aux_active};

   // Next-state, datapath and error bookkeeping.
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      frame_rx2_nxt  = frame_rx2;
      more_nxt       = more;
      aux_active_nxt = aux_active;
      aux_word_nxt   = aux_word;
      cap_nxt        = cap;
      tmo_cnt_nxt    = tmo_cnt;
      gap_cnt_nxt    = gap_cnt;
      data_nxt       = BUS_SPI_data_out;
      enable_nxt     = BUS_SPI_enable;
      read_req_nxt   = IQ_RX_READ_REQ;
      read_clk_nxt   = IQ_RX_READ_CLK;
      ack_nxt        = 1'b0;
      tmo_event      = 1'b0;
      ovr_event      = iq_edge && (state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            // A frame strobe takes priority; a pending aux request waits for the next idle slot.
            if (iq_edge) begin
               cap_nxt[W_RX1_I] = RX1_I;
               cap_nxt[W_RX1_Q] = RX1_Q;
               cap_nxt[W_RX2_I] = RX2_I;
               cap_nxt[W_RX2_Q] = RX2_Q;
               frame_rx2_nxt    = rx2_enable;
               read_req_nxt     = 1'b1;
               read_clk_nxt     = 1'b1;
               idx_nxt          = W_RX1_I;
               aux_active_nxt   = 1'b0;
               state_nxt        = ST_LOAD;
            end else if (aux_req) begin
               aux_word_nxt   = aux_data;
               aux_active_nxt = 1'b1;
               state_nxt      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            data_nxt  = aux_active ? aux_word : cap[idx];
            state_nxt = ST_START;
         end
         ST_START: begin
            enable_nxt  = 1'b1;
            tmo_cnt_nxt = '0;
            state_nxt   = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (BUS_SPI_busy) begin
               state_nxt = ST_WAIT_DONE;
            end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
               // Abort the word and the remainder of the frame; an aux request stays pending for retry.
               enable_nxt     = 1'b0;
               tmo_event      = 1'b1;
               read_req_nxt   = 1'b0;
               read_clk_nxt   = 1'b0;
               idx_nxt        = W_RX1_I;
               more_nxt       = 1'b0;
               aux_active_nxt = 1'b0;
               gap_cnt_nxt    = '0;
               state_nxt      = ST_GAP;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!BUS_SPI_busy) begin
               enable_nxt  = 1'b0;
               gap_cnt_nxt = '0;
               state_nxt   = ST_GAP;
               if (aux_active) begin
                  ack_nxt        = 1'b1;
                  aux_active_nxt = 1'b0;
                  more_nxt       = 1'b0;
               end else begin
                  if (idx == W_RX1_I) read_clk_nxt = 1'b0;
                  if (idx == last_word_idx(frame_rx2)) begin
                     read_req_nxt = 1'b0;
                     idx_nxt      = W_RX1_I;
                     more_nxt     = 1'b0;
                  end else begin
                     idx_nxt  = idx + IDX_W'(1);
                     more_nxt = 1'b1;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
               state_nxt = more ? ST_LOAD : ST_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A simultaneous event outranks err_clear.
      if (err_clear) begin
         ovr_nxt = ovr_event ? OVR_CNT_WIDTH'(1) : '0;
      end else if (ovr_event && (overrun_count != '1)) begin
         ovr_nxt = overrun_count + OVR_CNT_WIDTH'(1);
      end else begin
         ovr_nxt = overrun_count;
      end
      terr_nxt = err_clear ? tmo_event : (timeout_err | tmo_event);
   end

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         idx              <= '0;
         frame_rx2        <= 1'b0;
         more             <= 1'b0;
         aux_active       <= 1'b0;
         aux_word         <= '0;
         cap              <= '{default: '0};
         tmo_cnt          <= '0;
         gap_cnt          <= '0;
         BUS_SPI_data_out <= '0;
         BUS_SPI_enable   <= 1'b0;
         IQ_RX_READ_REQ   <= 1'b0;
         IQ_RX_READ_CLK   <= 1'b0;
         aux_ack          <= 1'b0;
         overrun_count    <= '0;
         timeout_err      <= 1'b0;
      end else begin
         state            <= state_nxt;
         idx              <= idx_nxt;
         frame_rx2        <= frame_rx2_nxt;
         more             <= more_nxt;
         aux_active       <= aux_active_nxt;
         aux_word         <= aux_word_nxt;
         cap              <= cap_nxt;
         tmo_cnt          <= tmo_cnt_nxt;
         gap_cnt          <= gap_cnt_nxt;
         BUS_SPI_data_out <= data_nxt;
         BUS_SPI_enable   <= enable_nxt;
         IQ_RX_READ_REQ   <= read_req_nxt;
         IQ_RX_READ_CLK   <= read_clk_nxt;
         aux_ack          <= ack_nxt;
         overrun_count    <= ovr_nxt;
         timeout_err      <= terr_nxt;
      end
   end

endmodule

// File: tb/tb_bus_spi_iq_scheduler.sv
// Randomized bench for bus_spi_iq_scheduler: a word-sequence model plus an SPI slave model.
module tb_bus_spi_iq_scheduler;

   logic        spi_clk = 1'b0;
   logic        reset_n;
   logic        iq_clk;
   logic        rx2_enable;
   logic [31:0] rx1_i, rx1_q, rx2_i, rx2_q;
   logic        read_req, read_clk;
   logic        aux_req;
   logic [31:0] aux_data;
   logic        aux_ack;
   logic [31:0] data_out;
   logic        enable;
   logic        busy;
   logic        err_clear;
   logic [7:0]  overrun_count;
   logic        timeout_err;
   logic [3:0]  stage;

   bus_spi_iq_scheduler dut (
      .spi_clk          (spi_clk),
      .reset_n          (reset_n),
      .iq_clk           (iq_clk),
      .rx2_enable       (rx2_enable),
      .RX1_I            (rx1_i),
      .RX1_Q            (rx1_q),
      .RX2_I            (rx2_i),
      .RX2_Q            (rx2_q),
      .IQ_RX_READ_REQ   (read_req),
      .IQ_RX_READ_CLK   (read_clk),
      .aux_req          (aux_req),
      .aux_data         (aux_data),
      .aux_ack          (aux_ack),
      .BUS_SPI_data_out (data_out),
      .BUS_SPI_enable   (enable),
      .BUS_SPI_busy     (busy),
      .err_clear        (err_clear),
      .overrun_count    (overrun_count),
      .timeout_err      (timeout_err),
      .BUS_SPI_Stage    (stage)
   );

   always #5 spi_clk = ~spi_clk;

   typedef struct {
      logic [31:0] data;
      bit          aux;
      int          k;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          busy_len    = 8;
   bit          never_busy  = 0;
   int          en_rises    = 0;
   int          last_en_len = 0;
   int          ack_cnt     = 0;
   int          exp_acks    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // SPI slave model: busy rises one cycle after enable, stays for busy_len cycles.
   // Also plays the aux requester, which withdraws aux_req on aux_ack.
   initial begin
      int ph = 0;
      int bcnt = 0;
      busy = 1'b0;
      forever begin
         @(negedge spi_clk);
         if (!reset_n) begin
            busy = 1'b0;
            ph   = 0;
         end else begin
            case (ph)
               0: if (enable && !never_busy) begin busy = 1'b1; bcnt = busy_len; ph = 1; end
               1: begin
                  bcnt--;
                  if (bcnt == 0) begin busy = 1'b0; ph = 2; end
               end
               default: if (!enable) ph = 0;
            endcase
            if (aux_ack) aux_req = 1'b0;
         end
      end
   end

   // Compare process: each word started must match the model queue; data stable while enabled.
   initial begin
      bit          prev_en  = 0;
      bit          prev_ack = 0;
      int          en_len   = 0;
      logic [31:0] held     = '0;
      exp_t        e;
      forever begin
         @(negedge spi_clk);
         if (!reset_n) begin
            prev_en = 0; prev_ack = 0; en_len = 0;
            continue;
         end
         if (enable && !prev_en) begin
            en_rises++;
            held   = data_out;
            en_len = 1;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {32'h0, data_out}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk(e.aux ? "aux_word" : $sformatf("frame_word%0d", e.k), {32'h0, data_out}, {32'h0, e.data});
               chk("read_req_at_word", {63'h0, read_req}, {63'h0, !e.aux});
               chk("read_clk_at_word", {63'h0, read_clk}, {63'h0, (!e.aux && e.k == 0)});
            end
         end else if (enable) begin
            en_len++;
            chk("data_stable", {32'h0, data_out}, {32'h0, held});
         end else if (prev_en) begin
            last_en_len = en_len;
         end
         if (aux_ack) begin
            ack_cnt++;
            chk("ack_single_pulse", {63'h0, prev_ack}, 64'h0);
         end
         prev_en  = enable;
         prev_ack = aux_ack;
      end
   end

   task automatic push_frame(input bit rx2, input logic [31:0] a, b, c, d);
      exp_t e;
      logic [31:0] w [4];
      w[0] = a; w[1] = b; w[2] = c; w[3] = d;
      for (int k = 0; k < (rx2 ? 4 : 2); k++) begin
         e.data = w[k]; e.aux = 0; e.k = k;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_aux(input logic [31:0] v);
      exp_t e;
      e.data = v; e.aux = 1; e.k = 0;
      exp_q.push_back(e);
      exp_acks++;
   endtask

   task automatic pulse_iq();
      @(negedge spi_clk);
      #2 iq_clk = 1'b1;
      repeat (3) @(negedge spi_clk);
      iq_clk = 1'b0;
      repeat (3) @(negedge spi_clk);
   endtask

   // Presents a frame; with_aux raises aux_req in the very cycle the frame strobe is detected.
   task automatic issue_frame(input bit rx2, input logic [31:0] a, b, c, d,
                              input bit with_aux, input logic [31:0] av);
      @(negedge spi_clk);
      rx2_enable = rx2; rx1_i = a; rx1_q = b; rx2_i = c; rx2_q = d;
      push_frame(rx2, a, b, c, d);
      @(negedge spi_clk);
      iq_clk = 1'b1;
      repeat (3) @(negedge spi_clk);
      if (with_aux) begin
         aux_data = av;
         aux_req  = 1'b1;
         push_aux(av);
      end
      iq_clk = 1'b0;
      repeat (3) @(negedge spi_clk);
   endtask

   task automatic issue_aux(input logic [31:0] v);
      @(negedge spi_clk);
      aux_data = v;
      aux_req  = 1'b1;
      push_aux(v);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || enable || aux_req || stage != 4'd0) && n < budget) begin
         @(negedge spi_clk);
         n++;
      end
      if (n >= budget) chk("drain_timeout", 64'(n), 64'(budget - 1));
      repeat (4) @(negedge spi_clk);
   endtask

   task automatic wait_rises(input int target, input int budget);
      int n = 0;
      while (en_rises < target && n < budget) begin
         @(negedge spi_clk);
         n++;
      end
      if (n >= budget) chk("wait_enable_timeout", 64'(en_rises), 64'(target));
   endtask

   initial begin
      int base;
      reset_n = 1'b0; iq_clk = 1'b0; rx2_enable = 1'b0;
      rx1_i = '0; rx1_q = '0; rx2_i = '0; rx2_q = '0;
      aux_req = 1'b0; aux_data = '0; err_clear = 1'b0;
      repeat (3) @(negedge spi_clk);
      chk("rst_enable",   {63'h0, enable},   64'h0);
      chk("rst_read_req", {63'h0, read_req}, 64'h0);
      chk("rst_read_clk", {63'h0, read_clk}, 64'h0);
      chk("rst_data_out", {32'h0, data_out}, 64'h0);
      chk("rst_overrun",  {56'h0, overrun_count}, 64'h0);
      chk("rst_timeout",  {63'h0, timeout_err}, 64'h0);
      chk("rst_stage",    {60'h0, stage}, 64'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge spi_clk);

      // Two-word frame with literal samples.
      busy_len = 8;
      issue_frame(0, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h0, 0, 32'h0);
      drain(400);
      chk("t1_read_req_end", {63'h0, read_req}, 64'h0);
      chk("t1_read_clk_end", {63'h0, read_clk}, 64'h0);

      // Four-word frame with extreme signed RX2 samples.
      issue_frame(1, 32'h01020304, 32'h05060708, 32'h80000000, 32'h7FFFFFFF, 0, 32'h0);
      drain(600);
      chk("t2_read_req_end", {63'h0, read_req}, 64'h0);

      // Aux request coincident with the frame strobe: frame first, then aux.
      issue_frame(0, 32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0, 1, 32'h5A5A5A5A);
      drain(600);
      chk("t3_ack_count", 64'(ack_cnt), 64'(exp_acks));

      // Randomized frames, aux words and coincident pairs.
      for (int it = 0; it < 14; it++) begin
         int sel = $urandom_range(0, 2);
         busy_len = $urandom_range(1, 12);
         if (sel == 1) issue_aux($urandom());
         else issue_frame(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom(),
                          sel == 2, $urandom());
         drain(1000);
         chk("rand_ack_count", 64'(ack_cnt), 64'(exp_acks));
         chk("rand_read_req_idle", {63'h0, read_req}, 64'h0);
         chk("rand_no_overrun", {56'h0, overrun_count}, 64'h0);
      end

      // Frame strobe during word 1 is dropped and counted.
      busy_len = 20;
      base = en_rises;
      issue_frame(0, 32'h0BAD0000, 32'h0BAD0001, 32'h0, 32'h0, 0, 32'h0);
      wait_rises(base + 2, 200);
      pulse_iq();
      drain(600);
      repeat (20) @(negedge spi_clk);
      chk("t4_overrun_one", {56'h0, overrun_count}, 64'd1);
      chk("t4_no_extra_frame", 64'(en_rises), 64'(base + 2));

      // 300 strobes during a long aux word saturate the counter.
      busy_len = 3000;
      base = en_rises;
      issue_aux(32'h00A0A0A0);
      wait_rises(base + 1, 50);
      for (int i = 0; i < 300; i++) pulse_iq();
      chk("t4_overrun_sat", {56'h0, overrun_count}, 64'd255);
      @(negedge spi_clk) err_clear = 1'b1;
      @(negedge spi_clk) err_clear = 1'b0;
      chk("t4_overrun_clear", {56'h0, overrun_count}, 64'd0);
      drain(4000);
      chk("t4_ack_count", 64'(ack_cnt), 64'(exp_acks));

      // Busy never asserted: word 0 aborted after 64 cycles, rest of frame dropped.
      busy_len = 6;
      never_busy = 1;
      issue_frame(0, 32'h7100D000, 32'h7100D001, 32'h0, 32'h0, 0, 32'h0);
      void'(exp_q.pop_back());
      drain(400);
      chk("t5_enable_len", 64'(last_en_len), 64'd64);
      chk("t5_timeout_err", {63'h0, timeout_err}, 64'h1);
      chk("t5_read_req", {63'h0, read_req}, 64'h0);
      chk("t5_read_clk", {63'h0, read_clk}, 64'h0);
      never_busy = 0;
      issue_frame(1, 32'h1, 32'h2, 32'h3, 32'h4, 0, 32'h0);
      drain(600);
      chk("t5_timeout_sticky", {63'h0, timeout_err}, 64'h1);
      @(negedge spi_clk) err_clear = 1'b1;
      @(negedge spi_clk) err_clear = 1'b0;
      chk("t5_timeout_clear", {63'h0, timeout_err}, 64'h0);

      // Asynchronous reset while the SPI master is busy.
      busy_len = 30;
      base = en_rises;
      issue_frame(0, 32'hDEADBEEF, 32'hFEEDFACE, 32'h0, 32'h0, 0, 32'h0);
      wait_rises(base + 1, 100);
      repeat (5) @(negedge spi_clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_enable_rst",   {63'h0, enable},   64'h0);
      chk("t6_read_req_rst", {63'h0, read_req}, 64'h0);
      chk("t6_read_clk_rst", {63'h0, read_clk}, 64'h0);
      exp_q.delete();
      repeat (3) @(negedge spi_clk);
      reset_n = 1'b1;
      busy_len = 5;
      repeat (3) @(negedge spi_clk);
      issue_frame(0, 32'h600D0000, 32'h600D0001, 32'h0, 32'h0, 0, 32'h0);
      drain(400);
      chk("t6_read_req_end", {63'h0, read_req}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
